// File: rtl/ex_stage_mdu_if.sv
// Execute-stage bus: control handshake, operands in, registered results and memory-stage drive out.
// master = control FSM side, slave = ex_stage_mdu.
interface ex_stage_mdu_if;
  logic        start;
  logic [3:0]  ALU_func;
  logic [31:0] RF_A;
  logic [31:0] RF_B;
  logic [31:0] Immed;
  logic        ALU_Bin_sel;
  logic [31:0] ALU_out;
  logic [31:0] HI_out;
  logic        ALU_zero;
  logic        ALU_ovf;
  logic [9:0]  MEM_addr;
  logic [31:0] MEM_datain;
  logic        busy;
  logic        done;

  modport master (
    output start, ALU_func, RF_A, RF_B, Immed, ALU_Bin_sel,
    input  ALU_out, HI_out, ALU_zero, ALU_ovf, MEM_addr, MEM_datain, busy, done
  );

  modport slave (
    input  start, ALU_func, RF_A, RF_B, Immed, ALU_Bin_sel,
    output ALU_out, HI_out, ALU_zero, ALU_ovf, MEM_addr, MEM_datain, busy, done
  );
endinterface

// File: rtl/ex_stage_mdu.sv
// MIPS execute stage: single-cycle ALU plus iterative 32-step unsigned mul/div,
// with registered results and a start/busy/done handshake.
module ex_stage_mdu (
  input  logic           clk,
  input  logic           reset,
  ex_stage_mdu_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOTA = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_ROL  = 4'b1100;
  localparam logic [3:0] OP_ROR  = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1110;
  localparam logic [3:0] OP_DIV  = 4'b1111;

  state_t      state_q, state_d;
  logic        accept, last_step, func_iter, busy_c, done_c;

  logic [31:0] b_mux, alu_res;
  logic        alu_ovf;
  logic [63:0] rot;

  logic        mul_q;
  logic [4:0]  cnt_q;
  logic [31:0] opnd_q, stb_q;
  logic [63:0] acc_q, acc_step;
  logic [32:0] mul_sum, div_shift;

  logic [31:0] alu_out_q, hi_out_q, mem_datain_q;
  logic        zero_q, ovf_q;

  assign b_mux     = bus.ALU_Bin_sel ? bus.Immed : bus.RF_B;
  assign func_iter = (bus.ALU_func == OP_MUL) || (bus.ALU_func == OP_DIV);
  assign last_step = (state_q == S_RUN) && (cnt_q == 5'd31);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = func_iter ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        busy_c = 1'b1;
        if (cnt_q == 5'd31) state_d = S_DONE;
      end
      S_DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          accept  = 1'b1;
          state_d = func_iter ? S_RUN : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle ALU; rotates take the matching half of the operand doubled up.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    rot     = '0;
    case (bus.ALU_func)
      OP_ADD: begin
        alu_res = bus.RF_A + b_mux;
        alu_ovf = (bus.RF_A[31] == b_mux[31]) && (alu_res[31] != bus.RF_A[31]);
      end
      OP_SUB: begin
        alu_res = bus.RF_A - b_mux;
        alu_ovf = (bus.RF_A[31] != b_mux[31]) && (alu_res[31] != bus.RF_A[31]);
      end
      OP_AND:  alu_res = bus.RF_A & b_mux;
      OP_OR:   alu_res = bus.RF_A | b_mux;
      OP_NOTA: alu_res = ~bus.RF_A;
      OP_NAND: alu_res = ~(bus.RF_A & b_mux);
      OP_NOR:  alu_res = ~(bus.RF_A | b_mux);
      OP_SRA:  alu_res = $signed(bus.RF_A) >>> b_mux[4:0];
      OP_SRL:  alu_res = bus.RF_A >> b_mux[4:0];
      OP_SLL:  alu_res = bus.RF_A << b_mux[4:0];
      OP_ROL: begin
        rot     = {bus.RF_A, bus.RF_A} << b_mux[4:0];
        alu_res = rot[63:32];
      end
      OP_ROR: begin
        rot     = {bus.RF_A, bus.RF_A} >> b_mux[4:0];
        alu_res = rot[31:0];
      end
      default: alu_res = '0;
    endcase
  end

  // acc_q is {hi, lo} for mul (lo starts as multiplier) and {remainder, quotient} for div.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    div_shift = acc_q[63:31];
    if (mul_q) begin
      acc_step = {mul_sum, acc_q[31:1]};
    end else if (div_shift >= {1'b0, opnd_q}) begin
      acc_step = {div_shift[31:0] - opnd_q, acc_q[30:0], 1'b1};
    end else begin
      acc_step = {div_shift[31:0], acc_q[30:0], 1'b0};
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_q        <= 1'b0;
      cnt_q        <= '0;
      opnd_q       <= '0;
      stb_q        <= '0;
      acc_q        <= '0;
      alu_out_q    <= '0;
      hi_out_q     <= '0;
      zero_q       <= 1'b1;
      ovf_q        <= 1'b0;
      mem_datain_q <= '0;
    end else if (accept) begin
      mul_q <= (bus.ALU_func == OP_MUL);
      stb_q <= bus.RF_B;
      cnt_q <= '0;
      if (func_iter) begin
        if (bus.ALU_func == OP_MUL) begin
          acc_q  <= {32'd0, b_mux};
          opnd_q <= bus.RF_A;
        end else begin
          acc_q  <= {32'd0, bus.RF_A};
          opnd_q <= b_mux;
        end
      end else begin
        alu_out_q    <= alu_res;
        hi_out_q     <= '0;
        zero_q       <= (alu_res == 32'd0);
        ovf_q        <= alu_ovf;
        mem_datain_q <= bus.RF_B;
      end
    end else if (state_q == S_RUN) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 5'd1;
      // Visible results change only at completion; a zero divisor naturally
      // yields an all-ones quotient and the dividend as remainder.
      if (last_step) begin
        alu_out_q    <= acc_step[31:0];
        hi_out_q     <= acc_step[63:32];
        zero_q       <= (acc_step[31:0] == 32'd0);
        ovf_q        <= 1'b0;
        mem_datain_q <= stb_q;
      end
    end
  end

  assign bus.ALU_out    = alu_out_q;
  assign bus.HI_out     = hi_out_q;
  assign bus.ALU_zero   = zero_q;
  assign bus.ALU_ovf    = ovf_q;
  assign bus.MEM_addr   = alu_out_q[11:2];
  assign bus.MEM_datain = mem_datain_q;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Self-checking bench for ex_stage_mdu: directed cases then randomized ops against
// an arithmetic reference model.
module tb_ex_stage_mdu;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] prev_lo;

  ex_stage_mdu_if bus ();

  ex_stage_mdu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, hi, lo}.
  function automatic logic [64:0] model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] lo, hi;
    logic        ovf;
    logic [63:0] prod;
    int          s;
    lo  = 32'd0;
    hi  = 32'd0;
    ovf = 1'b0;
    s   = int'(b[4:0]);
    case (f)
      4'd0: begin
        lo  = a + b;
        ovf = (longint'($signed(a)) + longint'($signed(b))) != longint'($signed(lo));
      end
      4'd1: begin
        lo  = a - b;
        ovf = (longint'($signed(a)) - longint'($signed(b))) != longint'($signed(lo));
      end
      4'd2:  lo = a & b;
      4'd3:  lo = a | b;
      4'd4:  lo = ~a;
      4'd5:  lo = ~(a & b);
      4'd6:  lo = ~(a | b);
      4'd8:  lo = 32'($signed(a) >>> s);
      4'd9:  lo = a >> s;
      4'd10: lo = a << s;
      4'd12: lo = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      4'd13: lo = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      4'd14: begin
        prod = 64'(a) * 64'(b);
        lo   = prod[31:0];
        hi   = prod[63:32];
      end
      4'd15: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: lo = 32'd0;
    endcase
    return {ovf, hi, lo};
  endfunction

  task automatic drive(input logic [3:0] f, input logic [31:0] a, input logic [31:0] rfb,
                       input logic [31:0] imm, input logic sel);
    bus.ALU_func    = f;
    bus.RF_A        = a;
    bus.RF_B        = rfb;
    bus.Immed       = imm;
    bus.ALU_Bin_sel = sel;
  endtask

  // Called at a negedge; issues one op, waits for done (bounded), checks results.
  // inject >= 1 pulses an add start on that RUN cycle, which must be ignored.
  task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] rfb,
                        input logic [31:0] imm, input logic sel, input int inject);
    logic [64:0] m;
    int          lat, exp_lat;
    m       = model(f, sel ? imm : rfb, 32'd0);
    m       = model(f, a, sel ? imm : rfb);
    exp_lat = (f == 4'd14 || f == 4'd15) ? 33 : 1;
    drive(f, a, rfb, imm, sel);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      check("busy_run", 64'(bus.busy), 64'd1);
      if (lat == 16) check("held_in_run", 64'(bus.ALU_out), 64'(prev_lo));
      if (lat == inject) begin
        drive(4'd0, $urandom, $urandom, $urandom, 1'b0);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check("latency", 64'(lat), 64'(exp_lat));
    check("busy_at_done", 64'(bus.busy), 64'd0);
    check("alu_out", 64'(bus.ALU_out), 64'(m[31:0]));
    check("hi_out", 64'(bus.HI_out), 64'(m[63:32]));
    check("ovf", 64'(bus.ALU_ovf), 64'(m[64]));
    check("zero", 64'(bus.ALU_zero), 64'(m[31:0] == 32'd0));
    check("mem_addr", 64'(bus.MEM_addr), 64'(m[11:2]));
    check("mem_datain", 64'(bus.MEM_datain), 64'(rfb));
    prev_lo = m[31:0];
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("done_pulse_end", 64'(bus.done), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_hold", 64'(bus.ALU_out), 64'(prev_lo));
  endtask

  initial begin
    logic       saw_done;
    logic [3:0] f;
    logic [31:0] a, b;

    reset     = 1'b1;
    bus.start = 1'b0;
    drive(4'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_alu_out", 64'(bus.ALU_out), 64'd0);
    check("rst_hi_out", 64'(bus.HI_out), 64'd0);
    check("rst_zero", 64'(bus.ALU_zero), 64'd1);
    check("rst_ovf", 64'(bus.ALU_ovf), 64'd0);
    check("rst_addr", 64'(bus.MEM_addr), 64'd0);
    check("rst_datain", 64'(bus.MEM_datain), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    reset   = 1'b0;
    prev_lo = 32'd0;
    @(negedge clk);

    // Directed cases
    run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, -1);
    idle_check();
    run_op(4'd0, 32'h100, 32'hCAFE_F00D, 32'h24, 1'b1, -1);
    idle_check();
    run_op(4'd14, 32'd7, 32'd6, 32'd0, 1'b0, -1);
    run_op(4'd14, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, -1);
    idle_check();
    run_op(4'd15, 32'd100, 32'd7, 32'd0, 1'b0, -1);
    run_op(4'd15, 32'd5, 32'd0, 32'd0, 1'b0, -1);
    idle_check();
    run_op(4'd14, 32'h0001_2345, 32'h777, 32'd0, 1'b0, 5);
    idle_check();
    run_op(4'd1, 32'h8000_0000, 32'd1, 32'd0, 1'b0, -1);
    run_op(4'd13, 32'h0000_00F1, 32'd0, 32'd4, 1'b1, -1);
    idle_check();

    // Reset on the 10th RUN cycle of a div, with a competing start
    drive(4'd15, 32'd1000, 32'd3, 32'd0, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b1;
    drive(4'd0, 32'd5, 32'd5, 32'd0, 1'b0);
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    check("rrun_busy", 64'(bus.busy), 64'd0);
    check("rrun_done", 64'(bus.done), 64'd0);
    check("rrun_alu_out", 64'(bus.ALU_out), 64'd0);
    check("rrun_hi_out", 64'(bus.HI_out), 64'd0);
    check("rrun_zero", 64'(bus.ALU_zero), 64'd1);
    saw_done = 1'b0;
    repeat (36) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("rrun_no_done", 64'(saw_done), 64'd0);
    prev_lo = 32'd0;

    // Randomized ops, mixing back-to-back starts and idle gaps
    for (int i = 0; i < 40; i++) begin
      f = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 4) == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 1) == 1)
        run_op(f, a, $urandom, b, 1'b1, -1);
      else
        run_op(f, a, b, $urandom, 1'b0, ($urandom_range(0, 3) == 0) ? 3 : -1);
      if ($urandom_range(0, 1) == 1) idle_check();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
